// File: rtl/sbox_stream.sv
// rtl/sbox_stream.sv - runtime-configurable NPORTS x NPORTS stream switch box with registered outputs
module sbox_stream #(
  parameter int WIDTH  = 32,
  parameter int NPORTS = 4,
  localparam int SELW  = $clog2(NPORTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [SELW-1:0]         cfg_addr,
  input  logic [SELW-1:0]         cfg_sel,
  input  logic                    cfg_en,
  input  logic [NPORTS*WIDTH-1:0] in_data,
  input  logic [NPORTS-1:0]       in_valid,
  output logic [NPORTS-1:0]       in_ready,
  output logic [NPORTS*WIDTH-1:0] out_data,
  output logic [NPORTS-1:0]       out_valid,
  input  logic [NPORTS-1:0]       out_ready
);
  localparam logic [SELW:0] NP = (SELW+1)'(NPORTS);

  logic [SELW-1:0]   sel [NPORTS];
  logic [NPORTS-1:0] en;
  logic [NPORTS-1:0] can_load;
  logic [NPORTS-1:0] load;
  logic [NPORTS-1:0] has_cons;
  logic [NPORTS-1:0] cons_ok;
  logic [WIDTH-1:0]  mux_data [NPORTS];
  logic              cfg_ok;

  assign cfg_ok   = cfg_we & ({1'b0, cfg_addr} < NP) & ({1'b0, cfg_sel} < NP);
  assign can_load = ~out_valid | out_ready;

  // An input is ready only when every enabled output selecting it can load, so broadcast is all-or-none.
  always_comb begin
    has_cons = '0;
    cons_ok  = '1;
    for (int j = 0; j < NPORTS; j++) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (en[i] && sel[i] == SELW'(j)) begin
          has_cons[j] = 1'b1;
          cons_ok[j]  = cons_ok[j] & can_load[i];
        end
      end
    end
  end

  assign in_ready = has_cons & cons_ok;

  always_comb begin
    load = '0;
    for (int i = 0; i < NPORTS; i++) begin
      mux_data[i] = '0;
      for (int j = 0; j < NPORTS; j++) begin
        if (sel[i] == SELW'(j)) begin
          mux_data[i] = in_data[j*WIDTH +: WIDTH];
          load[i]     = en[i] & in_valid[j] & in_ready[j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en        <= '0;
      out_valid <= '0;
      out_data  <= '0;
      for (int i = 0; i < NPORTS; i++) sel[i] <= SELW'(i);
    end else begin
      if (cfg_ok) begin
        sel[cfg_addr] <= cfg_sel;
        en[cfg_addr]  <= cfg_en;
      end
      for (int i = 0; i < NPORTS; i++) begin
        if (load[i]) begin
          out_data[i*WIDTH +: WIDTH] <= mux_data[i];
          out_valid[i]               <= 1'b1;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sbox_stream.sv
// tb/tb_sbox_stream.sv - self-checking bench for sbox_stream
module tb_sbox_stream;
  localparam int W  = 32;
  localparam int NP = 4;

  logic            clk;
  logic            reset;
  logic            cfg_we;
  logic [1:0]      cfg_addr, cfg_sel;
  logic            cfg_en;
  logic [NP*W-1:0] in_data, out_data;
  logic [NP-1:0]   in_valid, in_ready, out_valid, out_ready;

  logic            c3_we;
  logic [1:0]      c3_addr, c3_sel;
  logic            c3_en;
  logic [23:0]     in3_data, out3_data;
  logic [2:0]      in3_valid, in3_ready, out3_valid, out3_ready;

  int n_chk;
  int n_fail;

  sbox_stream #(.WIDTH(W), .NPORTS(NP)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel),
    .cfg_en(cfg_en), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  sbox_stream #(.WIDTH(8), .NPORTS(3)) dut3 (
    .clk(clk), .reset(reset), .cfg_we(c3_we), .cfg_addr(c3_addr), .cfg_sel(c3_sel),
    .cfg_en(c3_en), .in_data(in3_data), .in_valid(in3_valid), .in_ready(in3_ready),
    .out_data(out3_data), .out_valid(out3_valid), .out_ready(out3_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  iv;
    logic [3:0]  ordy;
    logic [3:0]  exp_ir;
    logic [3:0]  exp_ov;
    logic [7:0]  base;
    logic [31:0] exp_d;
  } vec_t;

  vec_t tbl [7];

  int             msel [NP];
  logic [W-1:0]   q [NP][$];
  int             rx [NP];
  logic [NP-1:0]  pend;
  logic [W-1:0]   pdata [NP];
  logic [NP-1:0]  exp_ir;
  bit             done, has, ok;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(int a, int s, bit e);
    cfg_addr = 2'(a);
    cfg_sel  = 2'(s);
    cfg_en   = e;
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic cfg3(int a, int s, bit e);
    c3_addr = 2'(a);
    c3_sel  = 2'(s);
    c3_en   = e;
    c3_we   = 1'b1;
    tick();
    c3_we   = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_sel = '0; cfg_en = 1'b0;
    in_data = '0; in_valid = '0; out_ready = '0;
    c3_we = 1'b0; c3_addr = '0; c3_sel = '0; c3_en = 1'b0;
    in3_data = '0; in3_valid = '0; out3_ready = '0;

    tbl[0] = '{4'hF, 4'hF, 4'hF, 4'hF, 8'h10, 32'h13121110};
    tbl[1] = '{4'h0, 4'h0, 4'h0, 4'hF, 8'h20, 32'h13121110};
    tbl[2] = '{4'hF, 4'h5, 4'h5, 4'hF, 8'h30, 32'h13321130};
    tbl[3] = '{4'h0, 4'hA, 4'hA, 4'h5, 8'h40, 32'h13321130};
    tbl[4] = '{4'hA, 4'h0, 4'hA, 4'hF, 8'h50, 32'h53325130};
    tbl[5] = '{4'hF, 4'hF, 4'hF, 4'hF, 8'h60, 32'h63626160};
    tbl[6] = '{4'h0, 4'hF, 4'hF, 4'h0, 8'h70, 32'h00000000};

    // Reset state
    tick(); tick();
    in_valid = 4'hF; out_ready = 4'hF;
    #2;
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data[31:0] | out_data[63:32] | out_data[95:64] | out_data[127:96], 0);
    tick();
    reset = 1'b1;
    tick();
    chk("post-reset in_ready (all disabled)", in_ready, 0);
    in_valid = '0;

    // Out-of-range config writes on the 3-port build
    cfg3(0, 2, 1'b1);
    cfg3(0, 3, 1'b0);
    cfg3(3, 0, 1'b1);
    in3_valid = 3'b111; in3_data = 24'hC2C1C0; out3_ready = 3'b111;
    #2;
    chk("np3 in_ready after ignored writes", in3_ready, 3'b100);
    tick();
    chk("np3 out_valid", out3_valid, 3'b001);
    chk("np3 out_data0", out3_data[7:0], 8'hC2);
    in3_valid = '0;

    // Identity routing, table-driven
    for (int i = 0; i < NP; i++) cfg(i, i, 1'b1);
    for (int k = 0; k < 7; k++) begin
      in_valid  = tbl[k].iv;
      out_ready = tbl[k].ordy;
      for (int j = 0; j < NP; j++) in_data[j*W +: W] = {24'h0, tbl[k].base + 8'(j)};
      #2;
      chk($sformatf("tbl%0d in_ready", k), in_ready, tbl[k].exp_ir);
      tick();
      chk($sformatf("tbl%0d out_valid", k), out_valid, tbl[k].exp_ov);
      for (int i = 0; i < NP; i++)
        if (tbl[k].exp_ov[i])
          chk($sformatf("tbl%0d out_data%0d", k, i), out_data[i*W +: W], {24'h0, tbl[k].exp_d[i*8 +: 8]});
    end
    in_valid = '0;

    // Broadcast N->E,S with E back-pressured; W->N
    cfg(1, 1, 1'b0);
    cfg(3, 0, 1'b1);
    cfg(2, 0, 1'b1);
    cfg(0, 1, 1'b1);
    in_valid = 4'b0001; in_data[31:0] = 32'h55; out_ready = 4'b0000;
    #2;
    chk("bc preload in_ready0", in_ready[0], 1);
    tick();
    in_data[31:0] = 32'hAA; out_ready = 4'b0100;
    #2;
    chk("bc stall in_ready", in_ready, 4'b0010);
    tick();
    chk("bc stall out_valid", out_valid, 4'b1000);
    chk("bc stall E held", out_data[127:96], 32'h55);
    out_ready = 4'hF;
    #2;
    chk("bc release in_ready0", in_ready[0], 1);
    tick();
    chk("bc out_valid", out_valid, 4'b1100);
    chk("bc S data", out_data[95:64], 32'hAA);
    chk("bc E data", out_data[127:96], 32'hAA);
    in_valid = '0;
    tick();

    // Reconfigure on a transfer cycle: old select applies to that word
    cfg(0, 0, 1'b1);
    cfg_addr = 2'd0; cfg_sel = 2'd1; cfg_en = 1'b1; cfg_we = 1'b1;
    in_valid = 4'b0011; in_data[31:0] = 32'hA0; in_data[63:32] = 32'hB0;
    #2;
    chk("recfg cycle in_ready", in_ready, 4'b0001);
    tick();
    cfg_we = 1'b0; in_valid = 4'b0010;
    chk("recfg old sel data", out_data[31:0], 32'hA0);
    chk("recfg old sel valid", out_valid[0], 1);
    #2;
    chk("recfg new sel in_ready1", in_ready[1], 1);
    tick();
    chk("recfg new sel data", out_data[31:0], 32'hB0);
    in_valid = '0;
    tick();

    // Randomised streaming against queue scoreboard
    for (int i = 0; i < NP; i++) begin
      msel[i] = $urandom_range(0, NP-1);
      cfg(i, msel[i], 1'b1);
      rx[i] = 0;
    end
    pend = '0;
    done = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      for (int j = 0; j < NP; j++)
        if (!pend[j] && $urandom_range(0, 3) != 0) begin
          pend[j]  = 1'b1;
          pdata[j] = $urandom;
        end
      for (int j = 0; j < NP; j++) in_data[j*W +: W] = pdata[j];
      in_valid  = pend;
      out_ready = 4'($urandom);
      #2;
      for (int j = 0; j < NP; j++) begin
        has = 1'b0; ok = 1'b1;
        for (int i = 0; i < NP; i++)
          if (msel[i] == j) begin
            has = 1'b1;
            if (q[i].size() != 0 && !out_ready[i]) ok = 1'b0;
          end
        exp_ir[j] = has & ok;
      end
      chk("rand in_ready", in_ready, exp_ir);
      for (int i = 0; i < NP; i++) begin
        chk($sformatf("rand out_valid%0d", i), out_valid[i], q[i].size() != 0);
        if (q[i].size() != 0) chk($sformatf("rand out_data%0d", i), out_data[i*W +: W], q[i][0]);
      end
      for (int i = 0; i < NP; i++)
        if (q[i].size() != 0 && out_ready[i]) begin
          void'(q[i].pop_front());
          rx[i]++;
        end
      for (int j = 0; j < NP; j++)
        if (pend[j] && exp_ir[j]) begin
          for (int i = 0; i < NP; i++) if (msel[i] == j) q[i].push_back(pdata[j]);
          pend[j] = 1'b0;
        end
      tick();
      done = 1'b1;
      for (int i = 0; i < NP; i++) if (rx[i] < 100) done = 1'b0;
    end
    chk("rand 100 words per output within budget", done, 1);

    // Reset while all outputs hold words
    in_valid = '0; out_ready = 4'hF;
    tick();
    for (int i = 0; i < NP; i++) cfg(i, i, 1'b1);
    out_ready = '0; in_valid = 4'hF;
    tick();
    chk("pre-reset out_valid", out_valid, 4'hF);
    #2;
    reset = 1'b0;
    #1;
    chk("async reset out_valid", out_valid, 0);
    chk("async reset in_ready", in_ready, 0);
    chk("async reset out_data0", out_data[31:0], 0);
    tick();
    reset = 1'b1;
    #2;
    chk("after reset in_ready unconfigured", in_ready, 0);
    tick();
    chk("after reset out_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
